mips_dump_sequencer: RTL
========================

Name: mips_dump_sequencer

Overview:
- Serializes a full MIPS debug snapshot to the UART transmitter, byte by byte, after each halt or step.
- Snapshot order: PC, clock count, register file, data memory.
- Drives the register/data-memory debug select buses into the MIPS and owns the tx start/done handshake.
- Sits between the debug unit, which raises `i_start`, and the UART tx interface.

Parameters:
- NBITS, 32, word width of PC, clock count, register and memory read-back.
- DATA_BITS, 8, UART byte width; NBITS must be a multiple of DATA_BITS.
- CELDAS_REG, 32, number of registers dumped.
- CELDAS_M, 16, number of data-memory words dumped.
- REG_SEL_BITS, $clog2(CELDAS_REG), register select width.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle request to begin a dump.
- i_mips_pc  in  NBITS  current PC.
- i_mips_clk_count  in  NBITS  MIPS clock counter.
- i_mips_reg  in  NBITS  register read-back for `o_mips_reg`.
- i_mips_mem  in  NBITS  data-memory read-back for `o_mips_mem`.
- i_uart_tx_done  in  1  one-cycle pulse: previous byte fully shifted out.
- o_mips_reg  out  REG_SEL_BITS  register select.
- o_mips_mem  out  NBITS  data-memory word index (zero-extended).
- o_uart_tx_data  out  DATA_BITS  byte to transmit.
- o_uart_tx_ready  out  1  one-cycle start pulse to the tx interface.
- o_busy  out  1  high from the cycle after `i_start` accepted until the DONE state.
- o_done  out  1  one-cycle pulse when the last byte's `i_uart_tx_done` is seen.

Behaviour:
- Reset values:
  - all outputs 0; state IDLE.
  - word counter, byte counter and shift register all 0.
- Frame: word 0 = PC, word 1 = clock count, words 2..CELDAS_REG+1 = registers 0..CELDAS_REG-1, then CELDAS_M memory words 0..CELDAS_M-1.
  - Total words W = 2+CELDAS_REG+CELDAS_M (default 50).
  - Each word is sent as NBITS/DATA_BITS bytes, LSB byte first (default 200 bytes).
- PC and clock count are snapshotted into holding registers in the cycle `i_start` is accepted. They are not re-read later.
- States:
  - IDLE: `i_start`=1 -> capture PC and clock count, word counter=0, go SELECT.
  - SELECT: drive `o_mips_reg` or `o_mips_mem` for the current word (unused select holds its last value), go SETTLE.
  - SETTLE: one cycle for read-back to settle, go LOAD.
  - LOAD: load the shift register from snapshot/`i_mips_reg`/`i_mips_mem`, byte counter=0, go SEND.
  - SEND: `o_uart_tx_data` = shift register[DATA_BITS-1:0], `o_uart_tx_ready`=1 for exactly this cycle, go WAIT.
  - WAIT: hold `o_uart_tx_data`; on `i_uart_tx_done`:
    - If more bytes remain: shift right by DATA_BITS, byte counter+1, go SEND.
    - Else if word counter < W-1: word counter+1, go SELECT.
    - Else: go DONE.
  - DONE: `o_done`=1 for one cycle, `o_busy`=0, go IDLE.
- Latency:
  - `i_start` to first `o_uart_tx_ready` is 4 cycles (SELECT, SETTLE, LOAD, SEND).
  - `i_uart_tx_done` to next `o_uart_tx_ready` is 1 cycle within a word, 4 cycles across words.
- `i_start` outside IDLE is ignored; no queuing.
- `i_uart_tx_done` outside WAIT is ignored.
- If `i_start` and `reset` are high in the same cycle, reset wins.
- Reset mid-dump: next cycle IDLE, all outputs 0, no `o_done` pulse.
  - A later `i_start` restarts from word 0.
- No timeout: WAIT holds indefinitely until `i_uart_tx_done`.
- Select widths: memory index counts 0..CELDAS_M-1, register index 0..CELDAS_REG-1.
  - Neither index wraps within one dump.
  - Counters are sized so W-1 is representable without overflow.

Test Plan:
- Basic dump:
  - Stimulus: PC=0x0000_0010, clk_count=0x0000_0007, reg[n]=n·0x0101_0101, mem[k]=0xA000_0000+k; tx model returns `i_uart_tx_done` 10 cycles after each `o_uart_tx_ready`.
  - Response: exactly 200 `o_uart_tx_ready` pulses.
  - Bytes 0-3 = 10 00 00 00; bytes 4-7 = 07 00 00 00.
  - Register 1 bytes (8-11 are reg 0) = 01 01 01 01; last 4 bytes = 0F 00 00 A0.
  - One `o_done` pulse after the final done.
- Snapshot stability: change `i_mips_pc` to 0xFFFF_FFFF in the cycle after `i_start` -> bytes 0-3 still 10 00 00 00.
- Select sequencing:
  - `o_mips_reg` steps 0..31, each value held during its SETTLE/LOAD cycles.
  - `o_mips_mem` steps 0..15 after the registers; 4-cycle start latency measured.
- Ignored inputs:
  - Pulse `i_start` during WAIT of word 5 -> the dump completes normally with 200 bytes and no second dump.
  - Spurious `i_uart_tx_done` in IDLE -> no output activity.
- Reset mid-operation:
  - Assert `reset` during byte 37 -> next cycle all outputs 0, `o_busy`=0, no `o_done`.
  - A new `i_start` then yields a full 200-byte frame starting with the PC bytes.
- Back-to-back:
  - `i_start` asserted in the cycle after `o_done` -> second full dump accepted.
  - Tx done with 0-cycle delay (the cycle after ready) -> no bytes dropped or duplicated.

Source files
------------

// File: rtl/mips_dump_sequencer.sv
// -----------------------------------------------------------------------------
// mips_dump_sequencer
//
// Serializes a complete MIPS debug snapshot to the UART transmitter, one byte
// at a time, whenever the debug unit requests it (after a halt or a step).
// Frame order: PC, clock count, register file (0..CELDAS_REG-1), then data
// memory words (0..CELDAS_M-1). Every word goes out LSB byte first.
//
// Ports:
//   clk              - system clock, all logic on the rising edge
//   reset            - synchronous, active-high reset
//   i_start          - one-cycle request to begin a dump (only honoured in IDLE)
//   i_mips_pc        - current PC, captured when the request is accepted
//   i_mips_clk_count - MIPS clock counter, captured with the PC
//   i_mips_reg       - register read-back for o_mips_reg
//   i_mips_mem       - data-memory read-back for o_mips_mem
//   i_uart_tx_done   - one-cycle pulse, previous byte fully shifted out
//   o_mips_reg       - register select into the MIPS
//   o_mips_mem       - data-memory word index (zero-extended)
//   o_uart_tx_data   - byte to transmit
//   o_uart_tx_ready  - one-cycle start pulse to the tx interface
//   o_busy           - dump in progress
//   o_done           - one-cycle pulse after the last byte has been sent
// -----------------------------------------------------------------------------
module mips_dump_sequencer #(
  parameter int NBITS        = 32,
  parameter int DATA_BITS    = 8,
  parameter int CELDAS_REG   = 32,
  parameter int CELDAS_M     = 16,
  parameter int REG_SEL_BITS = $clog2(CELDAS_REG)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_start,
  input  logic [NBITS-1:0]        i_mips_pc,
  input  logic [NBITS-1:0]        i_mips_clk_count,
  input  logic [NBITS-1:0]        i_mips_reg,
  input  logic [NBITS-1:0]        i_mips_mem,
  input  logic                    i_uart_tx_done,
  output logic [REG_SEL_BITS-1:0] o_mips_reg,
  output logic [NBITS-1:0]        o_mips_mem,
  output logic [DATA_BITS-1:0]    o_uart_tx_data,
  output logic                    o_uart_tx_ready,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int BYTES     = NBITS / DATA_BITS;
  localparam int WORDS     = 2 + CELDAS_REG + CELDAS_M;
  localparam int WORD_BITS = $clog2(WORDS);
  localparam int BYTE_BITS = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [WORD_BITS-1:0] LAST_WORD      = WORD_BITS'(WORDS - 1);
  localparam logic [WORD_BITS-1:0] FIRST_REG_WORD = WORD_BITS'(2);
  localparam logic [WORD_BITS-1:0] FIRST_MEM_WORD = WORD_BITS'(2 + CELDAS_REG);
  localparam logic [BYTE_BITS-1:0] LAST_BYTE      = BYTE_BITS'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    SETTLE = 3'd2,
    LOAD   = 3'd3,
    SEND   = 3'd4,
    WAIT   = 3'd5,
    DONE   = 3'd6
  } state_e;

  state_e                  state_r,     state_s;
  logic [WORD_BITS-1:0]    word_cnt_r,  word_cnt_s;
  logic [BYTE_BITS-1:0]    byte_cnt_r,  byte_cnt_s;
  logic [NBITS-1:0]        shift_r,     shift_s;
  logic [NBITS-1:0]        pc_snap_r,   pc_snap_s;
  logic [NBITS-1:0]        clk_snap_r,  clk_snap_s;
  logic [REG_SEL_BITS-1:0] reg_sel_r,   reg_sel_s;
  logic [NBITS-1:0]        mem_sel_r,   mem_sel_s;
  logic [DATA_BITS-1:0]    tx_data_r,   tx_data_s;
  logic                    tx_ready_r,  tx_ready_s;
  logic                    busy_r,      busy_s;
  logic                    done_r,      done_s;
  logic [NBITS-1:0]        load_word_s;

  // Source word for the shift register, chosen by the current word position.
  always_comb begin
    load_word_s = i_mips_mem;
    if (word_cnt_r == '0) begin
      load_word_s = pc_snap_r;
    end else if (word_cnt_r == WORD_BITS'(1)) begin
      load_word_s = clk_snap_r;
    end else if (word_cnt_r < FIRST_MEM_WORD) begin
      load_word_s = i_mips_reg;
    end else begin
      load_word_s = i_mips_mem;
    end
  end

  // Next-state and next-output computation; all outputs are registered from
  // the *_s values, so each output reflects the state it is registered with.
  always_comb begin
    state_s    = state_r;
    word_cnt_s = word_cnt_r;
    byte_cnt_s = byte_cnt_r;
    shift_s    = shift_r;
    pc_snap_s  = pc_snap_r;
    clk_snap_s = clk_snap_r;

    case (state_r)
      IDLE: begin
        if (i_start) begin
          pc_snap_s  = i_mips_pc;
          clk_snap_s = i_mips_clk_count;
          word_cnt_s = '0;
          state_s    = SELECT;
        end else begin
          state_s = IDLE;
        end
      end
      SELECT: state_s = SETTLE;
      SETTLE: state_s = LOAD;
      LOAD: begin
        shift_s    = load_word_s;
        byte_cnt_s = '0;
        state_s    = SEND;
      end
      SEND: state_s = WAIT;
      WAIT: begin
        if (!i_uart_tx_done) begin
          state_s = WAIT;
        end else if (byte_cnt_r != LAST_BYTE) begin
          shift_s    = shift_r >> DATA_BITS;
          byte_cnt_s = byte_cnt_r + BYTE_BITS'(1);
          state_s    = SEND;
        end else if (word_cnt_r < LAST_WORD) begin
          word_cnt_s = word_cnt_r + WORD_BITS'(1);
          state_s    = SELECT;
        end else begin
          state_s = DONE;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase

    // Selects are refreshed on entry to SELECT for the word about to be read;
    // the select not in use keeps its previous value.
    if ((state_s == SELECT) && (word_cnt_s >= FIRST_REG_WORD) &&
        (word_cnt_s < FIRST_MEM_WORD)) begin
      reg_sel_s = REG_SEL_BITS'(word_cnt_s - FIRST_REG_WORD);
    end else begin
      reg_sel_s = reg_sel_r;
    end

    if ((state_s == SELECT) && (word_cnt_s >= FIRST_MEM_WORD)) begin
      mem_sel_s = NBITS'(word_cnt_s - FIRST_MEM_WORD);
    end else begin
      mem_sel_s = mem_sel_r;
    end

    // tx data is updated only when a byte is launched and held otherwise.
    if (state_s == SEND) begin
      tx_data_s = shift_s[DATA_BITS-1:0];
    end else begin
      tx_data_s = tx_data_r;
    end

    tx_ready_s = (state_s == SEND);
    done_s     = (state_s == DONE);
    busy_s     = (state_s != IDLE) && (state_s != DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      word_cnt_r <= '0;
      byte_cnt_r <= '0;
      shift_r    <= '0;
      pc_snap_r  <= '0;
      clk_snap_r <= '0;
      reg_sel_r  <= '0;
      mem_sel_r  <= '0;
      tx_data_r  <= '0;
      tx_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      word_cnt_r <= word_cnt_s;
      byte_cnt_r <= byte_cnt_s;
      shift_r    <= shift_s;
      pc_snap_r  <= pc_snap_s;
      clk_snap_r <= clk_snap_s;
      reg_sel_r  <= reg_sel_s;
      mem_sel_r  <= mem_sel_s;
      tx_data_r  <= tx_data_s;
      tx_ready_r <= tx_ready_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign o_mips_reg      = reg_sel_r;
  assign o_mips_mem      = mem_sel_r;
  assign o_uart_tx_data  = tx_data_r;
  assign o_uart_tx_ready = tx_ready_r;
  assign o_busy          = busy_r;
  assign o_done          = done_r;

endmodule
